// File: rtl/serial_to_parallel_pkg.sv
// Shared definitions for the UART byte-to-word assembler: state encoding and size defaults.
package serial_to_parallel_pkg;

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } s2p_state_e;

    localparam int unsigned S2P_DEFAULT_N       = 16;
    localparam int unsigned S2P_DEFAULT_TIMEOUT = 1000000;

    function automatic int unsigned s2p_num_bytes(input int unsigned n);
        return n / 8;
    endfunction

endpackage

// File: rtl/s2p_idle_timer.sv
// Inter-byte idle counter for serial_to_parallel; expired flags the TIMEOUT_CYCLES-th idle clock.
module s2p_idle_timer
    import serial_to_parallel_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = S2P_DEFAULT_TIMEOUT
) (
    input  logic iCE_CLK,
    input  logic reset,
    input  logic clear,
    input  logic run,
    output logic expired
);

    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CntW-1:0] count_q;

    assign expired = run && (count_q == CntW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge iCE_CLK) begin
        if (reset || clear || expired) begin
            count_q <= '0;
        end else if (run) begin
            count_q <= count_q + CntW'(1);
        end
    end

endmodule

// File: rtl/serial_to_parallel.sv
// Assembles little-endian UART bytes into N-bit words with a valid/ready handshake.
// Optional partial-word idle timeout enabled by defining S2P_TIMEOUT_EN.
module serial_to_parallel
    import serial_to_parallel_pkg::*;
#(
    parameter int unsigned N              = S2P_DEFAULT_N,
    parameter int unsigned CNT_W          = 2,
    parameter int unsigned TIMEOUT_CYCLES = S2P_DEFAULT_TIMEOUT
) (
    input  logic         iCE_CLK,
    input  logic         reset,
    input  logic         rx_valid,
    input  logic [7:0]   rx_byte,
    input  logic         word_ready,
    output logic         word_valid,
    output logic [N-1:0] word,
    output logic         overflow,
    output logic         timeout
);

    localparam int unsigned    NumBytes = s2p_num_bytes(N);
    localparam logic [CNT_W-1:0] LastIdx = CNT_W'(NumBytes - 1);

    s2p_state_e       state_q;
    logic [CNT_W-1:0] idx_q;
    logic [CNT_W-1:0] wr_idx;
    logic [N-1:0]     word_q;
    logic [N-1:0]     word_wr;
    logic             valid_q;
    logic             overflow_q;
    logic             expired;

`ifdef S2P_TIMEOUT_EN
    logic timeout_q;
    logic accept;

    assign accept  = rx_valid && ((state_q == COLLECT) || word_ready);
    assign timeout = timeout_q;

    s2p_idle_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_idle_timer (
        .iCE_CLK(iCE_CLK),
        .reset  (reset),
        .clear  (accept),
        .run    ((state_q == COLLECT) && (idx_q != '0)),
        .expired(expired)
    );
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign expired            = 1'b0;
    assign timeout            = 1'b0;
`endif

    // A byte arriving in the timeout cycle starts a fresh word at lane 0.
    assign wr_idx = expired ? '0 : idx_q;

    always_comb begin
        word_wr = word_q;
        for (int b = 0; b < NumBytes; b++) begin
            if (wr_idx == CNT_W'(b)) begin
                word_wr[8*b +: 8] = rx_byte;
            end
        end
    end

    always_ff @(posedge iCE_CLK) begin
        if (reset) begin
            state_q    <= COLLECT;
            idx_q      <= '0;
            word_q     <= '0;
            valid_q    <= 1'b0;
            overflow_q <= 1'b0;
`ifdef S2P_TIMEOUT_EN
            timeout_q  <= 1'b0;
`endif
        end else begin
            overflow_q <= 1'b0;
`ifdef S2P_TIMEOUT_EN
            timeout_q  <= expired;
`endif
            unique case (state_q)
                COLLECT: begin
                    if (rx_valid) begin
                        word_q <= word_wr;
                        if (wr_idx == LastIdx) begin
                            state_q <= HOLD;
                            idx_q   <= '0;
                            valid_q <= 1'b1;
                        end else begin
                            idx_q <= wr_idx + CNT_W'(1);
                        end
                    end else if (expired) begin
                        idx_q <= '0;
                    end
                end
                HOLD: begin
                    if (word_ready) begin
                        state_q <= COLLECT;
                        valid_q <= 1'b0;
                        // Byte coincident with the handshake becomes byte 0 of the next word.
                        if (rx_valid) begin
                            word_q <= word_wr;
                            idx_q  <= CNT_W'(1);
                        end
                    end else if (rx_valid) begin
                        overflow_q <= 1'b1;
                    end
                end
                default: state_q <= COLLECT;
            endcase
        end
    end

    assign word_valid = valid_q;
    assign word       = word_q;
    assign overflow   = overflow_q;

endmodule

// File: doc/serial_to_parallel.md
SERIAL_TO_PARALLEL -- requirements
Module: serial_to_parallel

Interface
REQ-001 SHALL have parameter N, default 16: output word width in bits, a multiple of 8 and at least 16.
REQ-002 SHALL have parameter CNT_W, default 2: byte-index counter width, with 2^CNT_W >= N/8.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1000000: inter-byte idle limit in clocks.
REQ-004 SHALL have port iCE_CLK, input, 1 bit: the only clock; all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port rx_valid, input, 1 bit: one-cycle strobe marking a received UART byte.
REQ-007 SHALL have port rx_byte, input, 8 bits: received byte, valid only while rx_valid=1.
REQ-008 SHALL have port word_ready, input, 1 bit: the consumer accepts word this cycle.
REQ-009 SHALL have port word_valid, output, 1 bit: word holds a complete assembled value.
REQ-010 SHALL have port word, output, N bits: the assembled word.
REQ-011 SHALL have port overflow, output, 1 bit: one-cycle pulse when a byte is dropped.
REQ-012 SHALL have port timeout, output, 1 bit: one-cycle pulse when a partial word is discarded.

Function
REQ-013 SHALL implement two states: COLLECT and HOLD.
REQ-014 In COLLECT, each rx_valid SHALL write rx_byte into word[8*i+7:8*i], where i is the byte counter, then increment i; byte order is little-endian, first byte lands in [7:0].
REQ-015 When the byte with i = N/8-1 is accepted, the block SHALL enter HOLD, clear i to 0, and assert word_valid in the next cycle (latency 1 clock from the last rx_valid).
REQ-016 In HOLD, word and word_valid SHALL hold stable until word_valid && word_ready, after which word_valid SHALL drop in the next cycle and the state SHALL return to COLLECT.
REQ-017 rx_valid in HOLD without word_ready SHALL drop the byte and pulse overflow for exactly 1 cycle; word SHALL be unchanged.
REQ-018 rx_valid in the same cycle as the HOLD handshake SHALL be accepted as byte 0 of the next word, with no overflow.
REQ-019 word_ready while word_valid=0 SHALL have no effect.
REQ-020 Bytes not yet written in a partial word SHALL retain their previous contents; only word_valid qualifies word.

Reset
REQ-021 reset SHALL force state COLLECT, i=0, word=0, word_valid=0, overflow=0, timeout=0 and idle counter=0 on the next edge, overriding every other input.
REQ-022 reset asserted mid-word or in HOLD SHALL discard all collected data with no overflow or timeout pulse.

Configuration
REQ-023 With macro S2P_TIMEOUT_EN defined, an idle counter SHALL clear on every accepted byte and count clocks while in COLLECT with i != 0.
REQ-024 With S2P_TIMEOUT_EN defined, when the idle counter reaches TIMEOUT_CYCLES, i SHALL clear to 0 and timeout SHALL pulse for 1 cycle.
REQ-025 With S2P_TIMEOUT_EN defined, an rx_valid in the timeout cycle SHALL be accepted as byte 0.
REQ-026 Without S2P_TIMEOUT_EN, the timeout port SHALL be tied to 0, no idle counter SHALL exist, and partial words SHALL wait indefinitely.

Structure
REQ-027 The shared package/include SHALL hold the state encodings (COLLECT=1'b0, HOLD=1'b1), the default N, and the TIMEOUT_CYCLES default; parallel_to_serial uses the same N.
REQ-028 The idle counter SHALL be a sub-module named s2p_idle_timer (inputs clear and run; output expired), instantiated only under S2P_TIMEOUT_EN.

Verification
REQ-029 Bench SHALL check: N=16, bytes 0x34 then 0x12 with word_ready=1 -> word=0x1234, word_valid high exactly 1 cycle, 1 clock after the second strobe.
REQ-030 Bench SHALL check: N=32, bytes 0xEF,0xBE,0xAD,0xDE, word_ready=0 for 10 cycles then 1 -> word=0xDEADBEEF held stable for all 10 cycles, released on the handshake.
REQ-031 Bench SHALL check: N=16, HOLD with word_ready=0, byte 0x55 arrives -> overflow pulses 1 cycle, word unchanged; then 0xAA during the handshake cycle plus 0xBB -> next word=0xBBAA.
REQ-032 Bench SHALL check: after one byte 0x11, reset for 1 cycle, then 0x22,0x33 -> word=0x3322, no overflow or timeout pulse.
REQ-033 Bench SHALL check: with S2P_TIMEOUT_EN and TIMEOUT_CYCLES=8, byte 0x01 then 8 idle clocks -> timeout pulses once; then 0x02,0x03 -> word=0x0302.
REQ-034 Bench SHALL check: without S2P_TIMEOUT_EN, byte 0x01, 1000 idle clocks, then 0x02 -> word=0x0201, timeout never asserted.
